// File: rtl/alu_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Registered ALU with valid/ready handshakes. Single-cycle ops
//            (add/sub/logic/LUI/shifts) return one cycle after acceptance;
//            optional iterative shift-add multiplier (one bit per cycle).
// Config   : define ALU_PIPE_MUL_EN to build the multiplier and state MUL;
//            without it opcode 1000 behaves as an undefined code.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   alu_out,
  output logic                    ov,
  output logic                    zero,
  output logic                    busy
);

  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam int HALF = DATA_WIDTH / 2;
  localparam int MSB  = DATA_WIDTH - 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'b0000);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'b0100);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(4'b0001);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(4'b0101);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4'b0010);
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI = OPCODE_WIDTH'(4'b0110);
  localparam logic [OPCODE_WIDTH-1:0] OP_SLL = OPCODE_WIDTH'(4'b0011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SRL = OPCODE_WIDTH'(4'b0111);
  localparam logic [OPCODE_WIDTH-1:0] OP_SRA = OPCODE_WIDTH'(4'b1111);
`ifdef ALU_PIPE_MUL_EN
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL = OPCODE_WIDTH'(4'b1000);
  localparam logic [SHW-1:0]          LAST_CNT = SHW'(DATA_WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   alu_out_q, alu_out_d;
  logic                    ov_q, ov_d;
  logic                    zero_q, zero_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;

  logic [SHW-1:0]          shamt;
  logic [DATA_WIDTH-1:0]   add_res;
  logic [DATA_WIDTH-1:0]   sub_res;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_ov;
  logic                    accept;
  logic                    is_mul;

`ifdef ALU_PIPE_MUL_EN
  // multiplicand, {partial-product high half, remaining multiplier bits}
  logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*DATA_WIDTH-1:0] prod_q, prod_d;
  logic [2*DATA_WIDTH-1:0] prod_step;
  logic [DATA_WIDTH:0]     step_sum;
  logic [SHW-1:0]          cnt_q, cnt_d;
`endif

  assign shamt   = a[SHW-1:0];
  assign add_res = a + b;
  assign sub_res = a - b;

  // Reset gates in_ready so nothing is taken during a reset cycle
  assign in_ready = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  assign is_mul = (opcode == OP_MUL);
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle result and signed-overflow flag for the presented opcode
  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = add_res;
        alu_ov  = (a[MSB] == b[MSB]) && (add_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ov  = (a[MSB] != b[MSB]) && (sub_res[MSB] != a[MSB]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_LUI:  alu_res = {b[HALF-1:0], {HALF{1'b0}}};
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      default: begin
        alu_res = '0;
        alu_ov  = 1'b0;
      end
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  // One shift-add iteration: add multiplicand on multiplier LSB, shift right
  always_comb begin
    step_sum  = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]} +
                (prod_q[0] ? {1'b0, mcand_q} : {(DATA_WIDTH+1){1'b0}});
    prod_step = {step_sum, prod_q[DATA_WIDTH-1:1]};
  end
`endif

  // Next-state and next-output computation for the control FSM
  always_comb begin
    state_d     = state_q;
    alu_out_d   = alu_out_q;
    ov_d        = ov_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef ALU_PIPE_MUL_EN
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Result consumed: fall back to idle unless replaced below
        if ((state_q == ST_DONE) && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (is_mul) begin
`ifdef ALU_PIPE_MUL_EN
            state_d     = ST_MUL;
            busy_d      = 1'b1;
            out_valid_d = 1'b0;
            mcand_d     = a;
            prod_d      = {{DATA_WIDTH{1'b0}}, b};
            cnt_d       = '0;
`endif
          end else begin
            state_d     = ST_DONE;
            alu_out_d   = alu_res;
            ov_d        = alu_ov;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
`ifdef ALU_PIPE_MUL_EN
      ST_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + SHW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          alu_out_d   = prod_step[DATA_WIDTH-1:0];
          ov_d        = |prod_step[2*DATA_WIDTH-1:DATA_WIDTH];
          zero_d      = (prod_step[DATA_WIDTH-1:0] == '0);
        end
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any pending work
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_out_q   <= '0;
      ov_q        <= 1'b0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      alu_out_q   <= alu_out_d;
      ov_q        <= ov_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef ALU_PIPE_MUL_EN
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign ov        = ov_q;
  assign zero      = zero_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
